// File: rtl/tt_maquina_pkg.sv
// Shared definitions for the vending machine: event codes, switch channel indices
// and the order in which simultaneously pending events are queued.
package tt_maquina_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        EV_D = 2'd0,
        EV_N = 2'd1,
        EV_R = 2'd2,
        EV_P = 2'd3
    } ev_code_e;

    localparam logic [1:0] CH_D = 2'd0;
    localparam logic [1:0] CH_N = 2'd1;
    localparam logic [1:0] CH_R = 2'd2;
    localparam logic [1:0] CH_P = 2'd3;

    // Highest priority first; a channel index equals its event code.
    localparam logic [1:0] PRIO_ORDER [NUM_CH] = '{CH_R, CH_P, CH_D, CH_N};

    function automatic logic [NUM_CH-1:0] pick_grant(input logic [NUM_CH-1:0] pend);
        logic [NUM_CH-1:0] grant;
        grant = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend[PRIO_ORDER[i]]) begin
                grant = '0;
                grant[PRIO_ORDER[i]] = 1'b1;
            end else begin
                grant = grant;
            end
        end
        return grant;
    endfunction

    function automatic logic [1:0] grant_code(input logic [NUM_CH-1:0] grant);
        logic [1:0] code;
        code = 2'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                code = 2'(i);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/tt_maquina_debounce.sv
// One switch channel: two-flop synchronizer, stability counter and a one-cycle
// pulse when the debounced level rises.
module tt_maquina_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sw,
    output logic o_rise
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic       r_rise;
    logic [3:0] r_cnt;
    logic       w_mismatch;
    logic       w_settle;

    assign w_mismatch = r_sync2 ^ r_level;
    assign w_settle   = w_mismatch && (r_cnt == 4'(DEB_CYCLES - 1));
    assign o_rise     = r_rise;

    // Synchronize, count consecutive mismatches, accept level once stable long enough
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            if (w_settle) begin
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_cnt   <= 4'd0;
            end else if (w_mismatch) begin
                r_rise  <= 1'b0;
                r_cnt   <= r_cnt + 4'd1;
            end else begin
                r_rise  <= 1'b0;
                r_cnt   <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/tt_maquina_event_sched.sv
// Turns four bouncing user switches into a prioritized, show-ahead event queue
// for the vending core, with a sticky flag for events lost to a busy channel.
module tt_maquina_event_sched
    import tt_maquina_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw_raw,
    output logic       ev_valid,
    output logic [1:0] ev_code,
    input  logic       ev_ready,
    output logic [3:0] ev_count,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_grant;
    logic [NUM_CH-1:0] r_pend;
    logic [1:0]        w_code;
    logic              w_pop;
    logic              w_push;
    logic              w_can_write;
    logic              w_drop;
    logic              r_ovf;
    logic [1:0]        r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [3:0]        r_count;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tt_maquina_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk    (clk),
            .reset  (reset),
            .i_sw   (sw_raw[c]),
            .o_rise (w_rise[c])
        );
    end

    assign ev_valid    = (r_count != 4'd0);
    assign ev_code     = ev_valid ? r_mem[r_rd_ptr] : 2'd0;
    assign ev_count    = r_count;
    assign overflow    = r_ovf;
    assign w_pop       = ev_valid && ev_ready;
    // A full queue still takes a write when the head leaves in the same cycle.
    assign w_can_write = (r_count < 4'(FIFO_DEPTH)) || w_pop;
    assign w_grant     = w_can_write ? pick_grant(r_pend) : 4'd0;
    assign w_push      = |w_grant;
    assign w_code      = grant_code(w_grant);
    assign w_drop      = |(w_rise & r_pend);

    // Pending bits and the sticky drop flag (a new drop beats a clear)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= 4'd0;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_grant) | (w_rise & ~r_pend);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    // Queue storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 2'd0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_code;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Queue pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop  ? r_rd_ptr + PW'(1) : r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/tt_maquina_event_sched.md
TT_MAQUINA_EVENT_SCHED -- requirements
Module: tt_maquina_event_sched

Interface
REQ-001 Parameter DEB_CYCLES, default 4, SHALL set the consecutive stable synchronized cycles required to accept a level change (legal 2..15).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the event queue depth (power of two, 2..8).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 sw_raw  input  4  SHALL carry the asynchronous user switches {P,R,N,D}, bit3..bit0.
REQ-006 ev_valid  output  1  SHALL be high while the queue head holds an event.
REQ-007 ev_code  output  2  SHALL carry the head event code (D=0, N=1, R=2, P=3).
REQ-008 ev_ready  input  1  SHALL be asserted by the vending core to accept the head event.
REQ-009 ev_count  output  4  SHALL report the number of queued events, 0..FIFO_DEPTH.
REQ-010 overflow  output  1  SHALL be a sticky flag indicating at least one event was dropped.
REQ-011 ovf_clr  input  1  SHALL clear overflow on the next edge when high.

Function
REQ-012 Each sw_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each channel's debounced level SHALL update only after the synchronized value differs from it for DEB_CYCLES consecutive cycles; any mismatch gap SHALL reset that channel's counter to 0.
REQ-014 A 0->1 transition of a debounced level SHALL set that channel's pending bit; 1->0 transitions SHALL generate nothing.
REQ-015 A rising debounced edge on a channel whose pending bit is already set SHALL be dropped and SHALL set overflow.
REQ-016 Each cycle, if the queue can accept a write, the arbiter SHALL move exactly one pending bit into the queue, fixed priority R > P > D > N, and clear that pending bit.
REQ-017 The queue SHALL accept a write when ev_count < FIFO_DEPTH, or when ev_count = FIFO_DEPTH and ev_valid and ev_ready are both high in the same cycle.
REQ-018 When the queue cannot accept a write, pending bits SHALL hold unchanged (no loss, no overflow).
REQ-019 A pop SHALL occur when ev_valid and ev_ready are both high; ev_ready with ev_valid low SHALL be ignored.
REQ-020 The queue SHALL be show-ahead: ev_code is valid in the same cycle ev_valid rises, and SHALL be stable while ev_valid is high and ev_ready is low.
REQ-021 Simultaneous push and pop SHALL leave ev_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 Latency, sampled sw_raw rise to ev_valid high, SHALL be DEB_CYCLES+4 cycles with an empty queue and no other pending bits (2 sync + DEB_CYCLES + 1 pending + 1 write).
REQ-023 If ovf_clr and a new drop occur in the same cycle, overflow SHALL remain set (set wins).

Reset
REQ-024 Reset SHALL asynchronously clear synchronizers, debounce counters, debounced levels, pending bits, queue pointers, ev_count and overflow; ev_valid=0, ev_code=0 while in reset.
REQ-025 A switch held high through reset release SHALL produce exactly one event after the REQ-022 latency.
REQ-026 Reset asserted mid-operation SHALL discard all queued and pending events, with no event presented after release unless re-triggered per REQ-025.

Structure
REQ-027 Event codes, channel indices and the priority order SHALL reside in shared package tt_maquina_pkg, also used by the vending core.
REQ-028 One sub-module, tt_maquina_debounce (synchronizer + counter + edge detect, one channel), SHALL be instantiated four times; arbiter and queue SHALL be inline.

Verification
REQ-029 Single D press, held 20 cycles, ev_ready=1 -> one event, ev_code=0, ev_valid high exactly 1 cycle, first at cycle 8.
REQ-030 Bounce: N toggled every 2 cycles for 12 cycles then held high -> exactly one event, code 1.
REQ-031 R, P, D, N rising in the same cycle, ev_ready=0 -> queue order R, P, D, N (codes 2, 3, 0, 1); ev_count reaches 4.
REQ-032 Queue full, ev_ready=0, D pressed twice with a release between -> first press held pending, second press drops, overflow=1; ovf_clr pulse -> overflow=0.
REQ-033 Full queue with ev_ready=1 and pending P -> same-cycle pop and push, ev_count stays 4, P appears after the current entries.
REQ-034 Reset asserted with 3 queued events -> ev_valid=0, ev_count=0 immediately; no events after release with switches low.
